// File: rtl/slv_i2c_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : slv_i2c_reg_ctrl
// Description : Register-file controller that sits behind a byte-level I2C
//               slave core. It decodes the address byte, uses the first byte
//               of a write transfer as the register pointer, and then writes
//               or reads the register file with a pointer that auto-increments.
//               A local (user) write port shares the register file. When both
//               sides write the same register in the same cycle, the I2C write
//               is kept.
// Ports       : CLK, RST_n            - clock, async active-low reset
//               I_ADDR_SLV, I_RW      - address byte fields from the core
//               I_DATA_RD, I_DATA_VL  - received byte and its valid pulse
//               I_ACK_MSTR, I_BUSY    - master ACK/NACK, bus busy (START..STOP)
//               O_ACK, O_DATA_WR      - slave ACK enable, byte to transmit
//               I_USR_WE/ADDR/DATA    - local write port
//               O_USR_DATA            - combinational local read
//               O_WR_STB, O_WR_ADDR   - I2C write notification
//               O_COLL                - local write lost to an I2C write
// Revision    : 1.0 - initial release
// ============================================================================
module slv_i2c_reg_ctrl #(
    parameter int                 DATA_SZ  = 8,
    parameter int                 REG_NUM  = 16,
    parameter logic [DATA_SZ-2:0] SLV_ADDR = 7'h3C
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic [DATA_SZ-2:0]         I_ADDR_SLV,
    input  logic                       I_RW,
    input  logic [DATA_SZ-1:0]         I_DATA_RD,
    input  logic                       I_ACK_MSTR,
    input  logic                       I_BUSY,
    input  logic                       I_DATA_VL,
    output logic                       O_ACK,
    output logic [DATA_SZ-1:0]         O_DATA_WR,
    input  logic                       I_USR_WE,
    input  logic [$clog2(REG_NUM)-1:0] I_USR_ADDR,
    input  logic [DATA_SZ-1:0]         I_USR_DATA,
    output logic [DATA_SZ-1:0]         O_USR_DATA,
    output logic                       O_WR_STB,
    output logic [$clog2(REG_NUM)-1:0] O_WR_ADDR,
    output logic                       O_COLL
);

    localparam int AW = $clog2(REG_NUM);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_PTR    = 3'd2,
        ST_WR     = 3'd3,
        ST_RD     = 3'd4,
        ST_IGNORE = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [AW-1:0]      ptr;
    logic [AW-1:0]      ptr_nxt;
    logic               busy_q;
    logic               busy_rise;
    logic               busy_fall;
    logic               addr_match;
    logic               i2c_we;
    logic [DATA_SZ-1:0] regs [REG_NUM];

    assign busy_rise  = I_BUSY & ~busy_q;
    assign busy_fall  = ~I_BUSY & busy_q;
    assign addr_match = (I_ADDR_SLV == SLV_ADDR);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state, pointer update, write enable and ACK
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        i2c_we    = 1'b0;
        O_ACK     = 1'b0;

        case (state)
            ST_ADDR:   O_ACK = addr_match;
            ST_PTR,
            ST_WR,
            ST_RD:     O_ACK = 1'b1;
            default:   O_ACK = 1'b0;
        endcase

        // STOP wins over everything, including a byte completing in the
        // same cycle, so a truncated byte never reaches the register file.
        if (busy_fall) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (busy_rise) begin
                        state_nxt = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (I_DATA_VL) begin
                        if (!addr_match) begin
                            state_nxt = ST_IGNORE;
                        end else if (I_RW) begin
                            state_nxt = ST_RD;
                        end else begin
                            state_nxt = ST_PTR;
                        end
                    end
                end
                ST_PTR: begin
                    if (I_DATA_VL) begin
                        ptr_nxt   = I_DATA_RD[AW-1:0];
                        state_nxt = ST_WR;
                    end
                end
                ST_WR: begin
                    if (I_DATA_VL) begin
                        i2c_we  = 1'b1;
                        ptr_nxt = ptr + AW'(1);
                    end
                end
                ST_RD: begin
                    if (I_DATA_VL) begin
                        if (I_ACK_MSTR) begin
                            state_nxt = ST_IGNORE;
                        end else begin
                            ptr_nxt = ptr + AW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pointer, bus-busy history and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ptr       <= '0;
            // Held high in reset so a bus that is still busy when reset is
            // released is not mistaken for a fresh START; the block waits
            // for the bus to go idle and start again.
            busy_q    <= 1'b1;
            O_DATA_WR <= '0;
            O_WR_STB  <= 1'b0;
            O_WR_ADDR <= '0;
            O_COLL    <= 1'b0;
        end else begin
            ptr       <= ptr_nxt;
            busy_q    <= I_BUSY;
            O_DATA_WR <= regs[ptr];
            O_WR_STB  <= i2c_we;
            if (i2c_we) begin
                O_WR_ADDR <= ptr;
            end
            O_COLL    <= i2c_we & I_USR_WE & (I_USR_ADDR == ptr);
        end
    end

    // ------------------------------------------------------------------------
    // Register file: I2C write has priority over a local write to the same
    // entry; writes to different entries both complete.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                if (i2c_we && (ptr == AW'(i))) begin
                    regs[i] <= I_DATA_RD;
                end else if (I_USR_WE && (I_USR_ADDR == AW'(i))) begin
                    regs[i] <= I_USR_DATA;
                end
            end
        end
    end

    assign O_USR_DATA = regs[I_USR_ADDR];

endmodule
`default_nettype wire

// File: tb/tb_slv_i2c_reg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_slv_i2c_reg_ctrl
// Description : Self-checking bench for slv_i2c_reg_ctrl. Transactions are
//               driven at byte level; expectations come from a transaction
//               model (register array plus pointer) kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slv_i2c_reg_ctrl;

    localparam int         RN  = 16;
    localparam int         AW  = 4;
    localparam logic [6:0] OWN = 7'h3C;

    logic           CLK = 1'b0;
    logic           RST_n = 1'b0;
    logic [6:0]     I_ADDR_SLV = '0;
    logic           I_RW = 1'b0;
    logic [7:0]     I_DATA_RD = '0;
    logic           I_ACK_MSTR = 1'b0;
    logic           I_BUSY = 1'b0;
    logic           I_DATA_VL = 1'b0;
    logic           O_ACK;
    logic [7:0]     O_DATA_WR;
    logic           I_USR_WE = 1'b0;
    logic [AW-1:0]  I_USR_ADDR = '0;
    logic [7:0]     I_USR_DATA = '0;
    logic [7:0]     O_USR_DATA;
    logic           O_WR_STB;
    logic [AW-1:0]  O_WR_ADDR;
    logic           O_COLL;

    int total = 0;
    int bad   = 0;

    // transaction-level reference model
    logic [7:0] mregs [RN];
    int         mptr;
    logic [7:0] obs   [RN];

    slv_i2c_reg_ctrl #(.DATA_SZ(8), .REG_NUM(RN), .SLV_ADDR(OWN)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .I_ADDR_SLV (I_ADDR_SLV),
        .I_RW       (I_RW),
        .I_DATA_RD  (I_DATA_RD),
        .I_ACK_MSTR (I_ACK_MSTR),
        .I_BUSY     (I_BUSY),
        .I_DATA_VL  (I_DATA_VL),
        .O_ACK      (O_ACK),
        .O_DATA_WR  (O_DATA_WR),
        .I_USR_WE   (I_USR_WE),
        .I_USR_ADDR (I_USR_ADDR),
        .I_USR_DATA (I_USR_DATA),
        .O_USR_DATA (O_USR_DATA),
        .O_WR_STB   (O_WR_STB),
        .O_WR_ADDR  (O_WR_ADDR),
        .O_COLL     (O_COLL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    // ---------------- stimulus / observation helpers (no checks) ----------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < RN; i++) mregs[i] = '0;
        mptr = 0;
    endtask

    task automatic snap_regs();
        for (int i = 0; i < RN; i++) begin
            I_USR_ADDR = AW'(i);
            #1;
            obs[i] = O_USR_DATA;
        end
    endtask

    task automatic usr_write(input int a, input logic [7:0] d);
        I_USR_WE   = 1'b1;
        I_USR_ADDR = AW'(a);
        I_USR_DATA = d;
        tick();
        I_USR_WE   = 1'b0;
        mregs[a]   = d;
    endtask

    task automatic do_start();
        I_BUSY = 1'b1;
        tick();
        tick();
    endtask

    task automatic do_stop();
        I_BUSY = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_addr(input logic [6:0] a, input logic rw, output logic ack);
        I_ADDR_SLV = a;
        I_RW       = rw;
        I_DATA_VL  = 1'b1;
        #1;
        ack = O_ACK;
        tick();
        I_DATA_VL  = 1'b0;
        tick();
    endtask

    task automatic do_wbyte(input logic [7:0] d, output logic stb,
                            output logic [AW-1:0] wa, output logic stb2);
        I_DATA_RD = d;
        I_DATA_VL = 1'b1;
        tick();
        I_DATA_VL = 1'b0;
        stb = O_WR_STB;
        wa  = O_WR_ADDR;
        tick();
        stb2 = O_WR_STB;
    endtask

    task automatic do_rbyte(input logic nack, output logic [7:0] d, output logic ack);
        d          = O_DATA_WR;
        ack        = O_ACK;
        I_ACK_MSTR = nack;
        I_DATA_VL  = 1'b1;
        tick();
        I_DATA_VL  = 1'b0;
        I_ACK_MSTR = 1'b0;
        tick();
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        RST_n = 1'b0;
        model_clear();
        #23;
        total++; if (O_ACK !== 1'b0) begin bad++; $display("FAIL reset_ack: got %b want 0", O_ACK); end
        total++; if (O_DATA_WR !== 8'h00) begin bad++; $display("FAIL reset_data_wr: got %h want 00", O_DATA_WR); end
        total++; if (O_WR_STB !== 1'b0) begin bad++; $display("FAIL reset_wr_stb: got %b want 0", O_WR_STB); end
        total++; if (O_WR_ADDR !== '0) begin bad++; $display("FAIL reset_wr_addr: got %h want 0", O_WR_ADDR); end
        total++; if (O_COLL !== 1'b0) begin bad++; $display("FAIL reset_coll: got %b want 0", O_COLL); end
        snap_regs();
        for (int i = 0; i < RN; i++) begin
            total++; if (obs[i] !== 8'h00) begin bad++; $display("FAIL reset_reg%0d: got %h want 00", i, obs[i]); end
        end
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_write_burst();
        logic [7:0]    seq [4];
        logic          ack, stb, stb2;
        logic [AW-1:0] wa;
        int            exp_wa;
        seq[0] = 8'h0E; seq[1] = 8'hA1; seq[2] = 8'hB2; seq[3] = 8'hC3;
        do_start();
        do_addr(OWN, 1'b0, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL wb_addr_ack: got %b want 1", ack); end
        for (int k = 0; k < 4; k++) begin
            do_wbyte(seq[k], stb, wa, stb2);
            if (k == 0) begin
                mptr = seq[k] % RN;
                total++; if (stb !== 1'b0) begin bad++; $display("FAIL wb_ptr_stb: got %b want 0", stb); end
            end else begin
                exp_wa      = mptr;
                mregs[mptr] = seq[k];
                mptr        = (mptr + 1) % RN;
                total++; if (stb !== 1'b1) begin bad++; $display("FAIL wb_stb%0d: got %b want 1", k, stb); end
                total++; if (wa !== AW'(exp_wa)) begin bad++; $display("FAIL wb_wa%0d: got %0d want %0d", k, wa, exp_wa); end
                total++; if (stb2 !== 1'b0) begin bad++; $display("FAIL wb_stb_len%0d: got %b want 0", k, stb2); end
            end
        end
        do_stop();
        snap_regs();
        for (int i = 0; i < RN; i++) begin
            total++; if (obs[i] !== mregs[i]) begin bad++; $display("FAIL wb_reg%0d: got %h want %h", i, obs[i], mregs[i]); end
        end
    endtask

    task automatic test_read();
        logic [7:0] v, d;
        logic       ack;
        logic       nk [3];
        nk[0] = 1'b0; nk[1] = 1'b0; nk[2] = 1'b1;
        v = 8'($urandom_range(1, 255));
        usr_write(1, v);
        usr_write(2, v ^ 8'h5A);
        usr_write(3, v ^ 8'hC3);
        do_start();
        do_addr(OWN, 1'b1, ack);
        total++; if (ack !== 1'b1) begin bad++; $display("FAIL rd_addr_ack: got %b want 1", ack); end
        for (int k = 0; k < 3; k++) begin
            do_rbyte(nk[k], d, ack);
            total++; if (d !== mregs[mptr]) begin bad++; $display("FAIL rd_data%0d: got %h want %h", k, d, mregs[mptr]); end
            total++; if (ack !== 1'b1) begin bad++; $display("FAIL rd_ack%0d: got %b want 1", k, ack); end
            if (!nk[k]) mptr = (mptr + 1) % RN;
        end
        total++; if (O_ACK !== 1'b0) begin bad++; $display("FAIL rd_after_nack_ack: got %b want 0", O_ACK); end
        total++; if (O_DATA_WR !== mregs[mptr]) begin bad++; $display("FAIL rd_ptr_hold: got %h want %h", O_DATA_WR, mregs[mptr]); end
        do_stop();
        // pointer must persist into the next read transaction
        do_start();
        do_addr(OWN, 1'b1, ack);
        do_rbyte(1'b1, d, ack);
        total++; if (d !== mregs[mptr]) begin bad++; $display("FAIL rd_persist: got %h want %h", d, mregs[mptr]); end
        do_stop();
    endtask

    task automatic test_mismatch();
        logic          ack, stb, stb2;
        logic [AW-1:0] wa;
        do_start();
        do_addr(7'h3D, 1'b0, ack);
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL mm_ack: got %b want 0", ack); end
        for (int k = 0; k < 3; k++) begin
            do_wbyte(8'($urandom), stb, wa, stb2);
            total++; if ((stb | stb2) !== 1'b0) begin bad++; $display("FAIL mm_stb%0d: got %b want 0", k, stb | stb2); end
        end
        do_stop();
        snap_regs();
        for (int i = 0; i < RN; i++) begin
            total++; if (obs[i] !== mregs[i]) begin bad++; $display("FAIL mm_reg%0d: got %h want %h", i, obs[i], mregs[i]); end
        end
    endtask

    task automatic test_collision();
        logic          ack, stb, stb2, coll, coll2;
        logic [AW-1:0] wa;
        logic [7:0]    di, du;
        for (int pass = 0; pass < 2; pass++) begin
            di = 8'($urandom);
            du = ~di;
            do_start();
            do_addr(OWN, 1'b0, ack);
            do_wbyte(8'h05, stb, wa, stb2);
            mptr = 5;
            I_DATA_RD  = di;
            I_DATA_VL  = 1'b1;
            I_USR_WE   = 1'b1;
            I_USR_ADDR = AW'(5 + pass);
            I_USR_DATA = du;
            tick();
            I_DATA_VL  = 1'b0;
            I_USR_WE   = 1'b0;
            coll = O_COLL;
            stb  = O_WR_STB;
            tick();
            coll2 = O_COLL;
            if (pass == 1) mregs[6] = du;
            mregs[5] = di;
            mptr     = 6;
            total++; if (stb !== 1'b1) begin bad++; $display("FAIL coll_stb%0d: got %b want 1", pass, stb); end
            total++; if (coll !== (pass == 0)) begin bad++; $display("FAIL coll_pulse%0d: got %b want %b", pass, coll, pass == 0); end
            total++; if (coll2 !== 1'b0) begin bad++; $display("FAIL coll_len%0d: got %b want 0", pass, coll2); end
            do_stop();
            snap_regs();
            for (int i = 0; i < RN; i++) begin
                total++; if (obs[i] !== mregs[i]) begin bad++; $display("FAIL coll%0d_reg%0d: got %h want %h", pass, i, obs[i], mregs[i]); end
            end
        end
    endtask

    task automatic test_stop_coincident();
        logic          ack, stb, stb2;
        logic [AW-1:0] wa;
        logic [7:0]    p;
        p = 8'($urandom);
        do_start();
        do_addr(OWN, 1'b0, ack);
        do_wbyte(p, stb, wa, stb2);
        mptr = p % RN;
        I_DATA_RD = 8'($urandom);
        I_DATA_VL = 1'b1;
        I_BUSY    = 1'b0;
        tick();
        I_DATA_VL = 1'b0;
        stb = O_WR_STB;
        ack = O_ACK;
        tick();
        total++; if (stb !== 1'b0) begin bad++; $display("FAIL stopc_stb: got %b want 0", stb); end
        total++; if (ack !== 1'b0) begin bad++; $display("FAIL stopc_idle_ack: got %b want 0", ack); end
        // a byte while idle must be ignored
        do_wbyte(8'($urandom), stb, wa, stb2);
        total++; if ((stb | stb2) !== 1'b0) begin bad++; $display("FAIL idle_byte_stb: got %b want 0", stb | stb2); end
        snap_regs();
        for (int i = 0; i < RN; i++) begin
            total++; if (obs[i] !== mregs[i]) begin bad++; $display("FAIL stopc_reg%0d: got %h want %h", i, obs[i], mregs[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic          ack, stb, stb2;
        logic [AW-1:0] wa;
        do_start();
        do_addr(OWN, 1'b0, ack);
        do_wbyte(8'h03, stb, wa, stb2);
        I_DATA_RD = 8'($urandom_range(1, 255));
        I_DATA_VL = 1'b1;
        tick();
        I_DATA_VL = 1'b0;
        RST_n = 1'b0;
        #2;
        model_clear();
        total++; if (O_ACK !== 1'b0) begin bad++; $display("FAIL rmid_ack: got %b want 0", O_ACK); end
        total++; if (O_WR_STB !== 1'b0) begin bad++; $display("FAIL rmid_stb: got %b want 0", O_WR_STB); end
        total++; if (O_WR_ADDR !== '0) begin bad++; $display("FAIL rmid_wa: got %h want 0", O_WR_ADDR); end
        total++; if (O_DATA_WR !== 8'h00) begin bad++; $display("FAIL rmid_data_wr: got %h want 00", O_DATA_WR); end
        total++; if (O_COLL !== 1'b0) begin bad++; $display("FAIL rmid_coll: got %b want 0", O_COLL); end
        snap_regs();
        for (int i = 0; i < RN; i++) begin
            total++; if (obs[i] !== 8'h00) begin bad++; $display("FAIL rmid_reg%0d: got %h want 00", i, obs[i]); end
        end
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
        tick();
        // bus still busy: must wait for a fresh START, so this is ignored
        do_wbyte(8'h07, stb, wa, stb2);
        total++; if ((stb | stb2) !== 1'b0) begin bad++; $display("FAIL rmid_wait_stb: got %b want 0", stb | stb2); end
        total++; if (O_ACK !== 1'b0) begin bad++; $display("FAIL rmid_wait_ack: got %b want 0", O_ACK); end
        do_stop();
        test_write_burst();
    endtask

    task automatic test_random();
        logic          ack, stb, stb2, rw, match, nack;
        logic [AW-1:0] wa;
        logic [6:0]    a;
        logic [7:0]    d;
        int            n, exp_wa;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) usr_write($urandom_range(0, RN - 1), 8'($urandom));
            a     = ($urandom_range(0, 9) < 7) ? OWN : 7'($urandom);
            match = (a == OWN);
            rw    = 1'($urandom);
            do_start();
            do_addr(a, rw, ack);
            total++; if (ack !== match) begin bad++; $display("FAIL rnd%0d_addr_ack: got %b want %b", t, ack, match); end
            if (!rw) begin
                n = $urandom_range(1, 5);
                for (int k = 0; k < n; k++) begin
                    d = 8'($urandom);
                    do_wbyte(d, stb, wa, stb2);
                    if (match && k == 0) begin
                        mptr = d % RN;
                        total++; if (stb !== 1'b0) begin bad++; $display("FAIL rnd%0d_ptr_stb: got %b want 0", t, stb); end
                    end else if (match) begin
                        exp_wa      = mptr;
                        mregs[mptr] = d;
                        mptr        = (mptr + 1) % RN;
                        total++; if (stb !== 1'b1 || wa !== AW'(exp_wa) || stb2 !== 1'b0) begin
                            bad++; $display("FAIL rnd%0d_wr%0d: got stb=%b wa=%0d len=%b want stb=1 wa=%0d len=0", t, k, stb, wa, stb2, exp_wa);
                        end
                    end else begin
                        total++; if ((stb | stb2) !== 1'b0) begin bad++; $display("FAIL rnd%0d_ign_stb: got %b want 0", t, stb | stb2); end
                    end
                end
            end else begin
                n = $urandom_range(1, 4);
                for (int k = 0; k < n; k++) begin
                    nack = (k == n - 1) ? 1'($urandom) : 1'b0;
                    do_rbyte(nack, d, ack);
                    if (match) begin
                        total++; if (d !== mregs[mptr] || ack !== 1'b1) begin
                            bad++; $display("FAIL rnd%0d_rd%0d: got data=%h ack=%b want data=%h ack=1", t, k, d, ack, mregs[mptr]);
                        end
                        if (!nack) mptr = (mptr + 1) % RN;
                    end else begin
                        total++; if (ack !== 1'b0) begin bad++; $display("FAIL rnd%0d_ign_ack: got %b want 0", t, ack); end
                    end
                end
            end
            do_stop();
        end
        snap_regs();
        for (int i = 0; i < RN; i++) begin
            total++; if (obs[i] !== mregs[i]) begin bad++; $display("FAIL rnd_reg%0d: got %h want %h", i, obs[i], mregs[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read();
        test_mismatch();
        test_collision();
        test_stop_coincident();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
